fuzz_top: RTL and testbench

- Registered, single-clock mixed arithmetic/logic datapath that replaces the generated `top` fuzz design.
- Five input words are sampled every rising clock edge into six result registers. The registers are concatenated onto an 82-bit output bus.
- The block is a standalone leaf used for equivalence and simulation regression of the synthesis flow.

---
 rtl/fuzz_top_if.sv | 20 ++
 rtl/fuzz_top.sv | 74 +++++++
 tb/tb_fuzz_top.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fuzz_top_if.sv
// Operand and result bus for the fuzz_top datapath.
// The master drives the five operand words; the slave returns the packed result.
interface fuzz_top_if;
    logic [10:0] wire4;
    logic [8:0]  wire3;
    logic [9:0]  wire2;
    logic [11:0] wire1;
    logic [10:0] wire0;
    logic [81:0] y;

    modport master (
        output wire4, wire3, wire2, wire1, wire0,
        input  y
    );

    modport slave (
        input  wire4, wire3, wire2, wire1, wire0,
        output y
    );
endinterface

// File: rtl/fuzz_top.sv
// Registered mixed arithmetic/logic datapath.
// Six result registers are packed onto an 82-bit bus with one cycle of latency.
module fuzz_top (
    input  logic          clk,
    input  logic          rst,
    fuzz_top_if.slave     bus
);
    localparam int unsigned A_W   = 16;
    localparam int unsigned B_W   = 16;
    localparam int unsigned C_W   = 12;
    localparam int unsigned D_W   = 12;
    localparam int unsigned ACC_W = 18;
    localparam int unsigned CHK_W = 8;
    localparam int unsigned PRD_W = 17;

    logic [A_W-1:0]   r_a;
    logic [B_W-1:0]   r_b;
    logic [C_W-1:0]   r_c;
    logic [D_W-1:0]   r_d;
    logic [ACC_W-1:0] r_acc;
    logic [CHK_W-1:0] r_chk;

    logic signed [PRD_W-1:0] w_op_a;
    logic signed [PRD_W-1:0] w_op_m;
    logic signed [PRD_W-1:0] w_prod;
    logic [B_W-1:0]          w_sum;
    logic [3:0]              w_rot;
    logic [2*C_W-1:0]        w_dbl;
    logic signed [D_W-1:0]   w_b_ext;
    logic signed [D_W-1:0]   w_a_ext;
    logic [D_W-1:0]          w_max;
    logic [ACC_W-1:0]        w_acc_nxt;
    logic [CHK_W-1:0]        w_chk_nxt;

    // Next-value datapath; the multiplier operand is zero-extended so the product stays signed
    always_comb begin
        w_op_a    = {{(PRD_W-11){bus.wire4[10]}}, bus.wire4};
        w_op_m    = {{(PRD_W-5){1'b0}}, bus.wire3[4:0]};
        w_prod    = w_op_a * w_op_m;

        w_sum     = B_W'(bus.wire1) + B_W'(bus.wire0);

        w_rot     = (bus.wire3[3:0] >= 4'd12) ? (bus.wire3[3:0] - 4'd12) : bus.wire3[3:0];
        w_dbl     = {bus.wire1, bus.wire1} << w_rot;

        w_b_ext   = {{2{bus.wire2[9]}}, bus.wire2};
        w_a_ext   = {bus.wire4[10], bus.wire4};
        w_max     = (w_b_ext > w_a_ext) ? w_b_ext : w_a_ext;

        w_acc_nxt = bus.wire3[8] ? ACC_W'(bus.wire0) : (r_acc + ACC_W'(bus.wire0));
        w_chk_nxt = {r_chk[6:0], r_chk[7]} ^ bus.wire3[7:0];
    end

    // Result registers; reset wins over the accumulator reload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_d   <= '0;
            r_acc <= '0;
            r_chk <= '0;
        end else begin
            r_a   <= w_prod[A_W-1:0];
            r_b   <= w_sum;
            r_c   <= w_dbl[2*C_W-1:C_W];
            r_d   <= w_max;
            r_acc <= w_acc_nxt;
            r_chk <= w_chk_nxt;
        end
    end

    assign bus.y = {r_a, r_b, r_c, r_d, r_acc, r_chk};
endmodule

// File: tb/tb_fuzz_top.sv
// Directed self-checking bench for fuzz_top.
// Each vector is applied, one edge is taken, then the relevant y fields are compared.
module tb_fuzz_top;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    fuzz_top_if bus ();

    fuzz_top u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [81:0] act, input logic [81:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [10:0] w4, input logic [8:0] w3, input logic [9:0] w2,
                         input logic [11:0] w1, input logic [10:0] w0);
        bus.wire4 = w4;
        bus.wire3 = w3;
        bus.wire2 = w2;
        bus.wire1 = w1;
        bus.wire0 = w0;
    endtask

    // Take one rising edge and settle past it before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [81:0] f_a(input logic [81:0] v);   return 82'(v[81:66]); endfunction
    function automatic logic [81:0] f_b(input logic [81:0] v);   return 82'(v[65:50]); endfunction
    function automatic logic [81:0] f_c(input logic [81:0] v);   return 82'(v[49:38]); endfunction
    function automatic logic [81:0] f_d(input logic [81:0] v);   return 82'(v[37:26]); endfunction
    function automatic logic [81:0] f_acc(input logic [81:0] v); return 82'(v[25:8]);  endfunction
    function automatic logic [81:0] f_chk(input logic [81:0] v); return 82'(v[7:0]);   endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        drive(11'h5A3, 9'h1C7, 10'h2B1, 12'hABC, 11'h3D2);

        // Reset held for two edges with arbitrary inputs
        step();
        drive(11'h123, 9'h0F5, 10'h321, 12'h777, 11'h6AA);
        step();
        check_eq("reset_y", bus.y, 82'h0);

        // Checksum history from reset
        rst = 1'b0;
        drive(11'h000, 9'h081, 10'h000, 12'h000, 11'h000);
        step();
        check_eq("chk_81", f_chk(bus.y), 82'h81);
        drive(11'h000, 9'h000, 10'h000, 12'h000, 11'h000);
        step();
        check_eq("chk_03", f_chk(bus.y), 82'h03);
        drive(11'h000, 9'h0FF, 10'h000, 12'h000, 11'h000);
        step();
        check_eq("chk_f9", f_chk(bus.y), 82'hF9);

        // Accumulator wrap and reload
        do_reset();
        drive(11'h000, 9'h000, 10'h000, 12'h000, 11'h7FF);
        for (int i = 0; i < 128; i++) step();
        check_eq("acc_128", f_acc(bus.y), 82'h3FF80);
        step();
        check_eq("acc_wrap", f_acc(bus.y), 82'h0077F);
        drive(11'h000, 9'h100, 10'h000, 12'h000, 11'h005);
        step();
        check_eq("acc_reload", f_acc(bus.y), 82'h5);
        drive(11'h000, 9'h000, 10'h000, 12'h000, 11'h005);
        step();
        check_eq("acc_add", f_acc(bus.y), 82'hA);

        // Reset beats a simultaneous reload and clears the checksum
        rst = 1'b1;
        drive(11'h000, 9'h1AA, 10'h000, 12'h000, 11'h005);
        step();
        check_eq("rst_over_reload", f_acc(bus.y), 82'h0);
        check_eq("rst_chk", f_chk(bus.y), 82'h0);
        rst = 1'b0;

        // Multiply sign handling, add, rotate by 5, signed max of two negatives
        drive(11'h7FD, 9'h005, 10'h3FE, 12'hFFF, 11'h7FF);
        step();
        check_eq("a_neg3x5", f_a(bus.y), 82'hFFF1);
        check_eq("b_max", f_b(bus.y), 82'h17FE);
        check_eq("c_rot5", f_c(bus.y), 82'hFFF);
        check_eq("d_neg", f_d(bus.y), 82'hFFE);

        drive(11'h400, 9'h01F, 10'h200, 12'h001, 11'h000);
        step();
        check_eq("a_min_x31", f_a(bus.y), 82'h8400);
        check_eq("d_neg512", f_d(bus.y), 82'hE00);
        check_eq("c_rot15", f_c(bus.y), 82'h008);

        drive(11'h003, 9'h00D, 10'h3FE, 12'h001, 11'h001);
        step();
        check_eq("c_rot13", f_c(bus.y), 82'h002);
        check_eq("d_pos", f_d(bus.y), 82'h003);
        check_eq("a_3x13", f_a(bus.y), 82'h0027);
        check_eq("b_small", f_b(bus.y), 82'h0002);

        drive(11'h005, 9'h00B, 10'h005, 12'h001, 11'h010);
        step();
        check_eq("c_rot11", f_c(bus.y), 82'h800);
        check_eq("d_tie", f_d(bus.y), 82'h005);

        drive(11'h000, 9'h000, 10'h1FF, 12'hA5C, 11'h000);
        step();
        check_eq("c_rot0", f_c(bus.y), 82'hA5C);
        check_eq("a_zero", f_a(bus.y), 82'h0);
        check_eq("d_b_wins", f_d(bus.y), 82'h1FF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
